uds_fetch_arb: RTL

//  Arbiter/sequencer in front of the uds core. It shares the core's single read port between the CPU bus and a

---
 rtl/uds_fetch_arb_pkg.sv | 20 ++
 rtl/uds_fetch_arb_timer.sv | 28 ++
 rtl/uds_fetch_arb.sv | 126 ++++++++++++
 3 files changed

// File: rtl/uds_fetch_arb_pkg.sv
// Shared definitions for the UDS fetch arbiter: address map, word count, FSM states.
package uds_fetch_arb_pkg;

  localparam logic [7:0] ADDR_UDS_FIRST = 8'h10;
  localparam int         UDS_WORDS      = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

  // Word index to uds address.
  function automatic logic [7:0] uds_word_addr(input logic [2:0] i);
    return ADDR_UDS_FIRST + {5'b0, i};
  endfunction

endpackage

// File: rtl/uds_fetch_arb_timer.sv
// Loadable up-counter with clear/enable and a terminal-count flag; times the
// wait for seq_ack on each held word.
module uds_fetch_arb_timer #(
  parameter int           W      = 10,
  parameter logic [W-1:0] TC_VAL = '1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  // Clear has priority over load, load over count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  count <= '0;
    else if (clr)  count <= '0;
    else if (load) count <= load_val;
    else if (en)   count <= count + 1'b1;
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/uds_fetch_arb.sv
// Shares the uds read port between the CPU and a hardware consumer that pulls
// an 8-word burst with a valid/ack handshake. The CPU passes straight through
// while idle and is stalled while a burst owns the port.
module uds_fetch_arb
  import uds_fetch_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fw_app_mode,
  input  logic        cpu_cs,
  input  logic [7:0]  cpu_address,
  output logic [31:0] cpu_read_data,
  output logic        cpu_ready,
  input  logic        seq_start,
  output logic        seq_busy,
  output logic [31:0] seq_data,
  output logic        seq_valid,
  input  logic        seq_ack,
  output logic        seq_done,
  output logic        seq_error,
  output logic        uds_cs,
  output logic [7:0]  uds_address,
  input  logic [31:0] uds_read_data,
  input  logic        uds_ready
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  state_t      state;
  logic [2:0]  idx;
  logic        pending;
  logic [31:0] hold_reg;
  logic        valid_q, done_q, err_q;
  logic        tmo;
  logic        idle_pass;

  uds_fetch_arb_timer #(
    .W      (TW),
    .TC_VAL (TW'(TIMEOUT_CYCLES - 1))
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (state == ST_FETCH),
    .en       (state == ST_HOLD),
    .load     (1'b0),
    .load_val ('0),
    .tc       (tmo)
  );

  // Burst sequencer; done/error/valid are registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      pending  <= 1'b0;
      hold_reg <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A pending burst waits for a CPU-free cycle; the CPU wins collisions.
          if (pending) begin
            if (!cpu_cs) state <= ST_FETCH;
          end else if (seq_start) begin
            if (fw_app_mode) err_q   <= 1'b1;
            else             pending <= 1'b1;
          end
        end
        ST_FETCH: begin
          hold_reg <= uds_read_data;
          pending  <= 1'b0;
          valid_q  <= 1'b1;
          state    <= ST_HOLD;
        end
        ST_HOLD: begin
          // An ack in the timeout cycle still counts as accepted.
          if (seq_ack) begin
            valid_q <= 1'b0;
            if (idx == 3'(UDS_WORDS - 1)) begin
              idx      <= '0;
              hold_reg <= '0;
              done_q   <= 1'b1;
              state    <= ST_DONE;
            end else begin
              idx   <= idx + 3'd1;
              state <= ST_FETCH;
            end
          end else if (tmo) begin
            valid_q <= 1'b0;
            err_q   <= 1'b1;
            state   <= ST_ABORT;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        ST_ABORT: begin
          hold_reg <= '0;
          idx      <= '0;
          state    <= ST_IDLE;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Port mux: CPU pass-through when idle, sequencer fetch otherwise; all quiet in reset.
  always_comb begin
    idle_pass     = (state == ST_IDLE) && reset_n;
    uds_cs        = idle_pass ? cpu_cs : (state == ST_FETCH);
    uds_address   = idle_pass ? cpu_address :
                    ((state == ST_FETCH) ? uds_word_addr(idx) : 8'h00);
    cpu_read_data = idle_pass ? uds_read_data : 32'h0;
    cpu_ready     = idle_pass ? uds_ready : 1'b0;
    seq_valid     = valid_q;
    seq_data      = valid_q ? hold_reg : 32'h0;
    seq_done      = done_q;
    seq_error     = err_q;
    seq_busy      = pending || (state != ST_IDLE);
  end

endmodule
